mem_req_ctrl: RTL and testbench

Valid/ready request front-end for the single-port synchronous `memory` block, which has a one-cycle registered read. It accepts read/write requests from a producer and drives the memory's `write_enable`, `read_enable`, `address` and `write_data` pins. It captures `read_data` on the cycle it becomes valid and returns it through a small response FIFO with valid/ready backpressure. Issue is throttled by an occupancy credit, so no read response is ever lost.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_rsp_fifo.sv | 45 ++++
 rtl/memory.sv | 24 ++
 rtl/mem_req_ctrl.sv | 59 +++++
 tb/tb_mem_req_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults and request type for the memory request front-end
package mem_pkg;

    parameter int MEM_WIDTH = 8;
    parameter int MEM_DEPTH = 256;
    parameter int MEM_AW    = $clog2(MEM_DEPTH);

    typedef struct packed {
        logic                 write;
        logic [MEM_AW-1:0]    addr;
        logic [MEM_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo: small circular response FIFO with occupancy count
module mem_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       pop,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // pop only real entries; a push into a full FIFO is legal only alongside a pop
    assign do_pop   = pop && count != '0;
    assign do_push  = push && (count != CW'(DEPTH) || do_pop);
    assign data_out = count != '0 ? mem[rd_ptr] : '0;

    // storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    // pointers wrap modulo DEPTH; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/memory.sv
// memory: single-port synchronous RAM with a one-cycle registered read
module memory
    import mem_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH,
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     write_enable,
    input  logic                     read_enable,
    input  logic [$clog2(DEPTH)-1:0] address,
    input  logic [WIDTH-1:0]         write_data,
    output logic [WIDTH-1:0]         read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // write and registered read share the single address port
    always_ff @(posedge clk) begin
        if (write_enable) mem[address] <= write_data;
        if (read_enable) read_data <= mem[address];
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: credit-throttled valid/ready front-end for a single-port memory
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int WIDTH     = MEM_WIDTH,
    parameter int DEPTH     = MEM_DEPTH,
    parameter int RSP_DEPTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [$clog2(DEPTH)-1:0] req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_rdata,
    output logic                     mem_write_enable,
    output logic                     mem_read_enable,
    output logic [$clog2(DEPTH)-1:0] mem_address,
    output logic [WIDTH-1:0]         mem_write_data,
    input  logic [WIDTH-1:0]         mem_read_data
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          acc, rd_inflight;
    logic [CW-1:0] fifo_count;

    // a slot is reserved for every read in flight, so a response always has room
    assign req_ready        = !reset && (int'(fifo_count) + int'(rd_inflight) < RSP_DEPTH);
    assign acc              = req_valid && req_ready;
    assign mem_write_enable = acc && req_write;
    assign mem_read_enable  = acc && !req_write;
    assign mem_address      = req_addr;
    assign mem_write_data   = req_wdata;
    assign rsp_valid        = fifo_count != '0;

    // marks the cycle in which the memory's read_data is valid
    always_ff @(posedge clk) begin
        if (reset) rd_inflight <= 1'b0;
        else       rd_inflight <= mem_read_enable;
    end

    mem_rsp_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(RSP_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (rd_inflight),
        .data_in (mem_read_data),
        .pop     (rsp_ready),
        .data_out(rsp_rdata),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed cycle-accurate checks of mem_req_ctrl driving memory
module tb_mem_req_ctrl;
    import mem_pkg::*;

    logic       clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [7:0] req_addr = '0, req_wdata = '0;
    logic       req_ready, rsp_valid, mem_write_enable, mem_read_enable;
    logic [7:0] rsp_rdata, mem_address, mem_write_data, mem_read_data;
    int         n_vec = 0, n_err = 0, k;

    always #5 clk = ~clk;

    mem_req_ctrl #(.WIDTH(8), .DEPTH(256), .RSP_DEPTH(3)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    memory #(.WIDTH(8), .DEPTH(256)) u_mem (
        .clk(clk), .write_enable(mem_write_enable), .read_enable(mem_read_enable),
        .address(mem_address), .write_data(mem_write_data), .read_data(mem_read_data)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic mem_req_t wr(input logic [7:0] a, input logic [7:0] d);
        return '{write: 1'b1, addr: a, wdata: d};
    endfunction

    function automatic mem_req_t rd(input logic [7:0] a);
        return '{write: 1'b0, addr: a, wdata: 8'h00};
    endfunction

    // drive one cycle's inputs just after the edge, then settle at the falling edge
    task automatic tick(input logic r, input logic v, input mem_req_t q, input logic rr);
        @(posedge clk);
        #1;
        reset     = r;
        req_valid = v;
        req_write = q.write;
        req_addr  = q.addr;
        req_wdata = q.wdata;
        rsp_ready = rr;
        @(negedge clk);
    endtask

    initial begin
        // reset then idle
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, '0, 1'b0);
            chk("rst_ready", 8'(req_ready), 8'h00);
            chk("rst_rsp_valid", 8'(rsp_valid), 8'h00);
            chk("rst_we", 8'(mem_write_enable), 8'h00);
            chk("rst_re", 8'(mem_read_enable), 8'h00);
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            chk("rel_ready", 8'(req_ready), 8'h01);
            chk("rel_rsp_valid", 8'(rsp_valid), 8'h00);
            chk("rel_rdata", rsp_rdata, 8'h00);
            chk("rel_we_re", 8'({mem_write_enable, mem_read_enable}), 8'h00);
        end

        // write then read the same address
        tick(1'b0, 1'b1, wr(8'h10, 8'hA5), 1'b0);
        chk("wr_we", 8'(mem_write_enable), 8'h01);
        chk("wr_re", 8'(mem_read_enable), 8'h00);
        chk("wr_addr", mem_address, 8'h10);
        chk("wr_data", mem_write_data, 8'hA5);
        tick(1'b0, 1'b1, rd(8'h10), 1'b0);
        chk("rd_re", 8'(mem_read_enable), 8'h01);
        chk("rd_we", 8'(mem_write_enable), 8'h00);
        tick(1'b0, 1'b0, '0, 1'b0);
        chk("wr_rd_n2_valid", 8'(rsp_valid), 8'h00);
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("wr_rd_n3_valid", 8'(rsp_valid), 8'h01);
        chk("wr_rd_n3_data", rsp_rdata, 8'hA5);
        tick(1'b0, 1'b0, '0, 1'b0);
        chk("wr_rd_n4_valid", 8'(rsp_valid), 8'h00);

        // streaming writes then back-to-back reads
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, wr(8'(i), 8'(i) ^ 8'h3C), 1'b0);
            chk("stream_wr_ready", 8'(req_ready), 8'h01);
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, i < 8, rd(8'(i)), 1'b1);
            if (i < 8) chk("stream_rd_ready", 8'(req_ready), 8'h01);
            chk("stream_rsp_valid", 8'(rsp_valid), 8'(i >= 2));
            if (i >= 2) chk("stream_rsp_data", rsp_rdata, 8'(i - 2) ^ 8'h3C);
        end
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("stream_drained", 8'(rsp_valid), 8'h00);

        // backpressure: five reads offered, three fit
        k = 0;
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, 1'b1, rd(8'(k)), 1'b0);
            chk("bp_ready", 8'(req_ready), c < 3 ? 8'h01 : 8'h00);
            if (req_ready) k++;
        end
        chk("bp_accepted", 8'(k), 8'h03);
        for (int c = 0; c < 5; c++) begin
            tick(1'b0, k < 5, rd(8'(k)), 1'b1);
            if (c < 3) chk("bp_release_ready", 8'(req_ready), c == 0 ? 8'h00 : 8'h01);
            chk("bp_rsp_valid", 8'(rsp_valid), 8'h01);
            chk("bp_rsp_data", rsp_rdata, 8'(c) ^ 8'h3C);
            if (req_ready && req_valid) k++;
        end
        chk("bp_total", 8'(k), 8'h05);
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("bp_drained", 8'(rsp_valid), 8'h00);

        // push and pop together while two entries are queued and one is in flight
        for (int i = 5; i < 8; i++) begin
            tick(1'b0, 1'b1, rd(8'(i)), 1'b0);
            chk("full_fill_ready", 8'(req_ready), 8'h01);
        end
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("full_ready", 8'(req_ready), 8'h00);
        chk("full_data0", rsp_rdata, 8'h39);
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("full_pp_ready", 8'(req_ready), 8'h01);
        chk("full_pp_valid", 8'(rsp_valid), 8'h01);
        chk("full_data1", rsp_rdata, 8'h3A);
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("full_valid2", 8'(rsp_valid), 8'h01);
        chk("full_data2", rsp_rdata, 8'h3B);
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("full_drained", 8'(rsp_valid), 8'h00);

        // reset with two responses queued and one read in flight
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, rd(8'(i)), 1'b0);
        tick(1'b1, 1'b0, '0, 1'b0);
        chk("midrst_ready", 8'(req_ready), 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, '0, 1'b1);
            chk("midrst_valid", 8'(rsp_valid), 8'h00);
            chk("midrst_rdata", rsp_rdata, 8'h00);
            chk("midrst_ready_after", 8'(req_ready), 8'h01);
        end
        tick(1'b0, 1'b1, rd(8'h07), 1'b1);
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("post_rst_n1_valid", 8'(rsp_valid), 8'h00);
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("post_rst_valid", 8'(rsp_valid), 8'h01);
        chk("post_rst_data", rsp_rdata, 8'h3B);
        tick(1'b0, 1'b0, '0, 1'b1);
        chk("post_rst_drained", 8'(rsp_valid), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
